// File: rtl/sysid_regs_v2.sv
// sysid_regs_v2: system-ID / housekeeping register slave on an Avalon-MM style bus.
// Ports: clock, reset (sync, active-high); address/read/write/writedata request side;
//        readdata/readdatavalid return side, fixed 1-cycle read latency, no wait states.
module sysid_regs_v2 #(
  parameter logic [31:0]            SYS_ID        = 32'h0000_0000,
  parameter logic [31:0]            TIMESTAMP     = 32'h0000_0000,
  parameter logic [31:0]            SCRATCH_RESET = 32'h0000_0000,
  parameter int                     NUM_USER      = 4,
  parameter logic [32*NUM_USER-1:0] USER_WORDS    = {NUM_USER{32'h0}},
  parameter int                     ADDR_W        = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam logic [31:0] USER_BASE = 32'd8;
  localparam logic [31:0] USER_END  = 32'(8 + NUM_USER);

  logic [31:0] addr_ext;
  logic [31:0] scratch;
  logic [63:0] counter;
  logic [31:0] snapshot;
  logic        freeze;
  logic        ovf;
  logic        badaddr;
  logic [31:0] wr_count;
  logic [31:0] rd_mux;

  logic        unmapped;
  logic        ctrl_wr;
  logic        status_wr;
  logic        clear;
  logic        freeze_eff;
  logic        wrap;

  assign addr_ext  = 32'(address);
  assign unmapped  = (addr_ext >= USER_END);
  assign ctrl_wr   = write && (addr_ext == 32'd5);
  assign status_wr = write && (addr_ext == 32'd6);
  assign clear     = ctrl_wr && writedata[0];
  // A CONTROL write updates FREEZE on the same edge, so the counter already
  // obeys the newly written FREEZE value at that edge.
  assign freeze_eff = ctrl_wr ? writedata[1] : freeze;
  assign wrap       = !clear && !freeze_eff && (counter == '1);

  // Read mux; evaluated against pre-write state, so a simultaneous
  // read and write returns the old value.
  always_comb begin
    rd_mux = '0;
    case (addr_ext)
      32'd0: rd_mux = SYS_ID;
      32'd1: rd_mux = TIMESTAMP;
      32'd2: rd_mux = scratch;
      32'd3: rd_mux = counter[31:0];
      32'd4: rd_mux = snapshot;
      32'd5: rd_mux = {30'b0, freeze, 1'b0};
      32'd6: rd_mux = {30'b0, badaddr, ovf};
      32'd7: rd_mux = wr_count;
      default: begin
        for (int k = 0; k < NUM_USER; k++) begin
          if (addr_ext == USER_BASE + 32'(k)) begin
            rd_mux = USER_WORDS[32*k +: 32];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      scratch       <= SCRATCH_RESET;
      counter       <= '0;
      snapshot      <= '0;
      freeze        <= 1'b0;
      ovf           <= 1'b0;
      badaddr       <= 1'b0;
      wr_count      <= '0;
    end else begin
      readdatavalid <= read;
      if (read) begin
        readdata <= rd_mux;
      end
      // LO read latches the high half from the same edge for coherent LO/HI pairs.
      if (read && (addr_ext == 32'd3)) begin
        snapshot <= counter[63:32];
      end

      if (write && (addr_ext == 32'd2)) begin
        scratch  <= writedata;
        wr_count <= wr_count + 32'd1;
      end

      if (ctrl_wr) begin
        freeze <= writedata[1];
      end

      if (clear) begin
        counter <= '0;
      end else if (!freeze_eff) begin
        counter <= counter + 64'd1;
      end

      // Sticky bits: a new event in the same cycle beats the W1C.
      ovf     <= wrap | (ovf & ~(status_wr & writedata[0]));
      badaddr <= ((read | write) & unmapped) | (badaddr & ~(status_wr & writedata[1]));
    end
  end

endmodule

// File: tb/tb_sysid_regs_v2.sv
module tb_sysid_regs_v2;

  localparam int          AW     = 5;
  localparam logic [31:0] SYSID  = 32'h54D3_2F47;
  localparam logic [31:0] TSTAMP = 32'h1234_5678;
  localparam logic [31:0] SRST   = 32'hDEAD_BEEF;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          readdatavalid;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  sysid_regs_v2 #(
    .SYS_ID       (SYSID),
    .TIMESTAMP    (TSTAMP),
    .SCRATCH_RESET(SRST),
    .NUM_USER     (4),
    .USER_WORDS   ({32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000}),
    .ADDR_W       (AW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
  );

  always #5 clock = ~clock;

  // Scoreboard: every readdatavalid pops one expected word.
  always @(negedge clock) begin
    if (readdatavalid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_valid observed readdata=%08h expected no valid", readdata);
      end
      if (exp_q.size() != 0) begin
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (readdata === e) else begin
          errors++;
          $error("FAIL %s observed=%08h expected=%08h", t, readdata, e);
        end
      end
    end
  end

  task automatic rd(input int a, input logic [31:0] e, input string tag);
    read    = 1'b1;
    address = AW'(a);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clock);
    read = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    write     = 1'b1;
    address   = AW'(a);
    writedata = d;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    read      = 1'b0;
    write     = 1'b0;
    address   = '0;
    writedata = '0;
    repeat (3) @(negedge clock);

    checks++;
    assert (readdata === 32'h0) else begin
      errors++; $error("FAIL reset_readdata observed=%08h expected=00000000", readdata);
    end
    checks++;
    assert (readdatavalid === 1'b0) else begin
      errors++; $error("FAIL reset_valid observed=%0b expected=0", readdatavalid);
    end
    reset = 1'b0;

    // Identity and reset values, back-to-back reads.
    rd(0, SYSID, "sys_id");
    rd(1, TSTAMP, "timestamp");
    rd(2, SRST, "scratch_reset");
    rd(7, 32'd0, "count_reset");
    rd(6, 32'd0, "status_reset");
    rd(5, 32'd0, "control_reset");

    // Scratch write and write counter.
    wr(2, 32'hA5A5_0001);
    rd(2, 32'hA5A5_0001, "scratch_rw");
    rd(7, 32'd1, "count_one");

    // User words, first unmapped word, far unmapped address, BADADDR.
    rd(8, 32'hCAFE_0000, "user0");
    rd(11, 32'hCAFE_0003, "user3");
    rd(12, 32'h0, "unmapped_12");
    rd(30, 32'h0, "unmapped_30");
    rd(6, 32'd2, "status_badaddr");
    wr(6, 32'd2);
    rd(6, 32'd0, "status_badaddr_clr");

    // RO write is ignored and does not flag BADADDR.
    wr(0, 32'hFFFF_FFFF);
    rd(0, SYSID, "ro_write_ignored");
    rd(6, 32'd0, "ro_write_no_badaddr");

    // Coherent LO/HI snapshot across a 32-bit carry.
    read    = 1'b1;
    address = AW'(3);
    exp_q.push_back(32'hFFFF_FFFE);
    tag_q.push_back("uptime_lo");
    force dut.counter = 64'h0000_0000_FFFF_FFFE;
    @(posedge clock);
    #1 release dut.counter;
    @(negedge clock);
    read = 1'b0;
    idle(5);
    rd(4, 32'h0, "uptime_hi_snapshot");

    // 64-bit wrap sets OVF.
    force dut.counter = 64'hFFFF_FFFF_FFFF_FFFE;
    @(posedge clock);
    #1 release dut.counter;
    @(negedge clock);
    idle(3);
    rd(6, 32'd1, "status_ovf");

    // Wrap and W1C in the same cycle: set wins.
    write     = 1'b1;
    address   = AW'(6);
    writedata = 32'd1;
    force dut.counter = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clock);
    #1 release dut.counter;
    @(negedge clock);
    write = 1'b0;
    rd(6, 32'd1, "ovf_set_beats_clr");
    wr(6, 32'd1);
    rd(6, 32'd0, "ovf_clr");

    // CLEAR with FREEZE: counter zeroed and held.
    wr(5, 32'd3);
    rd(3, 32'd0, "clear_lo");
    idle(5);
    rd(3, 32'd0, "clear_lo_held");
    rd(5, 32'd2, "control_freeze_only");

    // Unfreeze: counts from the writing edge.
    wr(5, 32'd0);
    rd(3, 32'd1, "run_lo_1");
    rd(3, 32'd2, "run_lo_2");

    // FREEZE alone holds the current value.
    wr(5, 32'd2);
    rd(3, 32'd3, "freeze_lo_a");
    idle(10);
    rd(3, 32'd3, "freeze_lo_b");
    rd(4, 32'd0, "freeze_hi");
    wr(5, 32'd0);

    // Simultaneous read and write returns the pre-write value.
    read      = 1'b1;
    write     = 1'b1;
    address   = AW'(2);
    writedata = 32'h5A5A_0002;
    exp_q.push_back(32'hA5A5_0001);
    tag_q.push_back("rw_same_cycle_old");
    @(negedge clock);
    read  = 1'b0;
    write = 1'b0;
    rd(2, 32'h5A5A_0002, "rw_same_cycle_new");
    rd(7, 32'd2, "count_two");

    // Read, then reset on the next cycle together with another read.
    wr(6, 32'd2);
    rd(2, 32'h5A5A_0002, "read_before_reset");
    read    = 1'b1;
    address = AW'(0);
    reset   = 1'b1;
    @(negedge clock);
    read = 1'b0;
    checks++;
    assert (readdatavalid === 1'b0) else begin
      errors++; $error("FAIL reset_suppress_valid observed=%0b expected=0", readdatavalid);
    end
    @(negedge clock);
    checks++;
    assert (readdatavalid === 1'b0) else begin
      errors++; $error("FAIL reset_hold_valid observed=%0b expected=0", readdatavalid);
    end
    reset = 1'b0;

    rd(2, SRST, "post_reset_scratch");
    rd(7, 32'd0, "post_reset_count");
    rd(6, 32'd0, "post_reset_status");
    rd(5, 32'd0, "post_reset_control");
    rd(4, 32'd0, "post_reset_hi");

    idle(3);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++; $error("FAIL missing_valids observed=%0d pending expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
